result_reader: RTL and testbench
================================

Name: result_reader

Overview:
- Read-side engine for the result RAM that the matrix-multiply datapath fills.
- After the multiply reports done, a start pulse makes it walk RAM addresses 0..DEPTH-1 in order, using the RAM's 1-cycle synchronous read.
- Each word is streamed out over a valid/ready interface, with a final-beat marker and a running checksum.
- A 2-entry FIFO absorbs the read latency so downstream backpressure never loses or duplicates data.

Parameters:
- DEPTH, 64, number of result words to read (8x8 result matrix).
- ADDR_W, 8, result RAM address width.
- DATA_W, 19, result word width; matches the MAC accumulator width.
- CSUM_W, 24, checksum width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin readout; sampled only in IDLE.
- ram_addr  out  ADDR_W  result RAM read address.
- ram_rd_en  out  1  read issued this cycle.
- ram_data  in  DATA_W  RAM read data; valid the cycle after ram_rd_en.
- out_data  out  DATA_W  stream data.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  high with the beat for address DEPTH-1.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final beat is accepted.
- checksum  out  CSUM_W  running sum of accepted beats.

Behaviour:
- Reset (asynchronous, active-high): FSM to IDLE. Reset values:
  - ram_addr=0, ram_rd_en=0, out_valid=0, out_last=0, busy=0, done=0, checksum=0.
  - FIFO emptied, in-flight flag cleared.
- Reset mid-operation: aborts immediately with the same values; any partial stream is discarded.
- FSM IDLE:
  - start=1 at a clock edge -> FETCH, busy=1, checksum cleared to 0, issue pointer=0.
- FSM FETCH:
  - Define occupancy = FIFO count + in-flight read (0/1).
  - Pop = out_valid && out_ready.
  - Issue a read (ram_rd_en=1, ram_addr=issue pointer) when occupancy<2, or when occupancy==2 and a pop occurs this cycle.
  - After issuing address DEPTH-1 -> DRAIN; no further reads.
- FSM DRAIN:
  - Wait until the FIFO is empty and no read is in flight, with the last beat accepted.
  - Then pulse done=1 for one cycle, set busy=0 and go to IDLE.
- Read latency:
  - A read issued in cycle T returns ram_data in cycle T+1; the FIFO captures it at the end of T+1.
  - That word is presented on out_data/out_valid from cycle T+2.
- Start-to-first-beat: start sampled at edge E0 -> first read in the cycle after E0 -> out_valid=1 two cycles after that read.
- Throughput: with out_ready held high, one beat per cycle sustained; no bubbles after the first beat.
- Stream rules:
  - out_data, out_valid and out_last hold stable while out_valid=1 and out_ready=0.
  - A beat transfers only when both out_valid and out_ready are high.
  - out_valid never drops without a transfer.
- out_last: a tag stored alongside each FIFO entry; set only for the DEPTH-1 word.
- checksum:
  - checksum += zero-extended out_data on every transfer, modulo 2^CSUM_W.
  - The value is final and stable once done pulses; it holds until the next accepted start.
- FIFO full: with 2 entries stored and no pop, no read is issued.
  - The in-flight accounting guarantees no overflow; overflow is a design error to be caught by assertion.
- start while busy: ignored, no restart; start held high continuously re-triggers only from IDLE.
- done and start in the same cycle: done is produced in DRAIN, so start is not accepted that cycle; it is accepted the next cycle in IDLE.
- Address wrap: the issue pointer stops at DEPTH-1 and never wraps within one run.
- Order: the stream is strictly address order 0..DEPTH-1.
- The caller only asserts start after the multiplier's done, so no write contention on the result RAM exists.

Test Plan:
- Reset then idle: assert reset mid-cycle, hold start=0 -> all outputs 0, ram_rd_en never high.
- Full-rate readout: RAM[i]=i+1, out_ready=1, start pulse:
  - ram_rd_en first high the cycle after start; out_valid two cycles later.
  - 64 consecutive beats with data 1..64; out_last only on data 64.
  - done pulses once the cycle after the final beat; checksum=2080.
- Backpressure: same RAM, out_ready toggling 1,0,0,1 repeating:
  - Same 64 values in order, no duplicates.
  - out_data stable during every ready=0 cycle; checksum=2080.
- Max-value words: RAM all 0x7FFFF, DEPTH=64 -> checksum=0x1FFFFC0 mod 2^24=0xFFFFC0.
- Start while busy: second start pulse at beat 10 -> ignored; exactly 64 beats and one done pulse.
- Reset mid-stream: reset after 20 beats -> outputs clear immediately. A new start then yields a clean 64-beat stream from address 0; checksum restarts from 0.

Source files
------------

// File: rtl/result_reader_if.sv
// Interface for the result reader. It carries the result RAM read port and
// the valid/ready output stream.
interface result_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 19
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output ram_addr,
        output ram_rd_en,
        input  ram_data,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  ram_addr,
        input  ram_rd_en,
        output ram_data,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/result_reader.sv
// Reads result RAM addresses 0..DEPTH-1 through a 1-cycle synchronous read.
// Each word is streamed out through a 2-entry FIFO, and a running checksum is
// kept over the accepted beats.
module result_reader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 19,
    parameter int CSUM_W = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    result_reader_if.master      bus,
    output logic                 busy,
    output logic                 done,
    output logic [CSUM_W-1:0]    checksum
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] issue_ptr;
    logic              in_flight, in_flight_last;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_last;
    logic              rd_ptr, wr_ptr;
    logic [1:0]        fifo_count;
    logic [1:0]        occupancy;
    logic              fifo_push, fifo_pop, issue, last_addr;

    assign fifo_push = in_flight;
    assign fifo_pop  = bus.out_valid && bus.out_ready;
    assign occupancy = fifo_count + {1'b0, in_flight};
    assign last_addr = (issue_ptr == ADDR_W'(DEPTH - 1));

    // An in-flight read counts as occupied, so the FIFO can never overflow.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                issue = (occupancy < 2'd2) || ((occupancy == 2'd2) && fifo_pop);
                if (issue && last_addr) state_next = DRAIN;
            end
            DRAIN: begin
                if ((fifo_count == 2'd0) && !in_flight) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.ram_rd_en = issue;
    assign bus.ram_addr  = issue_ptr;
    assign busy          = (state != IDLE);
    assign bus.out_valid = (fifo_count != 2'd0);
    assign bus.out_data  = fifo_data[rd_ptr];
    assign bus.out_last  = bus.out_valid && fifo_last[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            issue_ptr      <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            checksum       <= '0;
        end else begin
            state          <= state_next;
            in_flight      <= issue;
            in_flight_last <= issue && last_addr;
            if ((state == IDLE) && start) begin
                issue_ptr <= '0;
                checksum  <= '0;
            end else begin
                if (issue && !last_addr) issue_ptr <= issue_ptr + ADDR_W'(1);
                if (fifo_pop) checksum <= checksum + CSUM_W'(bus.out_data);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            fifo_last  <= 2'b00;
        end else begin
            if (fifo_push) begin
                fifo_last[wr_ptr] <= in_flight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (fifo_pop) rd_ptr <= ~rd_ptr;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage for the FIFO words. It has no reset, because the count gates every use.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_data[wr_ptr] <= bus.ram_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && !fifo_pop && (fifo_count == 2'd2)));

endmodule

// File: tb/tb_result_reader.sv
// Directed testbench for result_reader. A RAM model feeds the reader, and a
// negedge monitor checks every beat against the bench's own memory image.
module tb_result_reader;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 19;
    localparam int CSUM_W = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic [CSUM_W-1:0] checksum;

    int tests_run    = 0;
    int tests_failed = 0;
    int ready_mode   = 0;

    int beat_count;
    int done_count;
    int last_count;
    int cyc;
    int last_beat_cyc;

    logic [DATA_W-1:0] mem [DEPTH];

    result_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    result_reader #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CSUM_W(CSUM_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_rd_en) bus.ram_data <= mem[bus.ram_addr[5:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues a start pulse. It returns 1 time unit after the edge that accepts the pulse.
    task automatic applyStimulus();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic waitBeats(input string name, input int target);
        int n;
        n = 0;
        while (beat_count < target && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        checkOutput({name, "_reach_beats"}, 32'(beat_count >= target), 32'd1);
    endtask

    task automatic runCheck(input string name, input logic [CSUM_W-1:0] exp_sum);
        int n;
        n = 0;
        while (done_count == 0 && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        checkOutput({name, "_done_seen"}, 32'(done_count > 0), 32'd1);
        repeat (5) begin @(posedge clk); #2; end
        checkOutput({name, "_beats"},    32'(beat_count), 32'(DEPTH));
        checkOutput({name, "_dones"},    32'(done_count), 32'd1);
        checkOutput({name, "_lasts"},    32'(last_count), 32'd1);
        checkOutput({name, "_busy"},     32'(busy), 32'd0);
        checkOutput({name, "_checksum"}, 32'(checksum), 32'(exp_sum));
    endtask

    initial begin : ready_drv
        int phase;
        phase = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) begin
                bus.out_ready = 1'b1;
            end else begin
                bus.out_ready = (phase == 0 || phase == 3);
                phase = (phase + 1) % 4;
            end
        end
    end

    // The monitor owns the beat bookkeeping. It restarts whenever a start is accepted or reset is seen.
    initial begin : monitor
        logic              prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic              prev_last;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        beat_count = 0; done_count = 0; last_count = 0; cyc = 0; last_beat_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                beat_count = 0; done_count = 0; last_count = 0;
                prev_stall = 1'b0;
            end else begin
                if (start && !busy) begin
                    beat_count = 0; done_count = 0; last_count = 0;
                end
                if (prev_stall) begin
                    checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
                    checkOutput("hold_data",  32'(bus.out_data),  32'(prev_data));
                    checkOutput("hold_last",  32'(bus.out_last),  32'(prev_last));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (beat_count < DEPTH) begin
                        checkOutput("beat_data", 32'(bus.out_data), 32'(mem[beat_count[5:0]]));
                        checkOutput("beat_last", 32'(bus.out_last), 32'(beat_count == DEPTH - 1));
                    end
                    if (bus.out_last) last_count++;
                    beat_count++;
                    last_beat_cyc = cyc;
                end
                if (done) begin
                    done_count++;
                    checkOutput("done_latency", 32'(cyc - last_beat_cyc), 32'd1);
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                prev_last  = bus.out_last;
            end
        end
    end

    initial begin : main
        int rd_seen;
        start = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i + 1);

        #3 reset = 1'b1;
        #1;
        checkOutput("rst_valid",    32'(bus.out_valid), 32'd0);
        checkOutput("rst_rd_en",    32'(bus.ram_rd_en), 32'd0);
        checkOutput("rst_addr",     32'(bus.ram_addr),  32'd0);
        checkOutput("rst_last",     32'(bus.out_last),  32'd0);
        checkOutput("rst_busy",     32'(busy),          32'd0);
        checkOutput("rst_done",     32'(done),          32'd0);
        checkOutput("rst_checksum", 32'(checksum),      32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        rd_seen = 0;
        repeat (10) begin
            @(posedge clk); #2;
            if (bus.ram_rd_en) rd_seen++;
        end
        checkOutput("idle_rd_en",  32'(rd_seen),       32'd0);
        checkOutput("idle_valid",  32'(bus.out_valid), 32'd0);
        checkOutput("idle_busy",   32'(busy),          32'd0);

        // Full-rate readout, including the start-to-first-beat latency.
        ready_mode = 0;
        applyStimulus();
        #1;
        checkOutput("lat_rd_en0", 32'(bus.ram_rd_en), 32'd1);
        checkOutput("lat_addr0",  32'(bus.ram_addr),  32'd0);
        checkOutput("lat_busy",   32'(busy),          32'd1);
        checkOutput("lat_valid0", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #2;
        checkOutput("lat_valid1", 32'(bus.out_valid), 32'd0);
        checkOutput("lat_addr1",  32'(bus.ram_addr),  32'd1);
        @(posedge clk); #2;
        checkOutput("lat_valid2", 32'(bus.out_valid), 32'd1);
        checkOutput("lat_data2",  32'(bus.out_data),  32'd1);
        runCheck("full", 24'd2080);
        repeat (3) @(posedge clk);
        #2 checkOutput("full_csum_hold", 32'(checksum), 32'd2080);

        // Backpressure with out_ready cycling through 1,0,0,1.
        ready_mode = 1;
        applyStimulus();
        runCheck("bp", 24'd2080);
        ready_mode = 0;

        // Every word at its maximum value, so the checksum wraps.
        for (int i = 0; i < DEPTH; i++) mem[i] = 19'h7FFFF;
        applyStimulus();
        runCheck("max", 24'hFFFFC0);

        // A second start while busy must not restart the run.
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i + 1);
        applyStimulus();
        waitBeats("busy_start", 10);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checkOutput("busy_start_busy", 32'(busy), 32'd1);
        runCheck("busy_start", 24'd2080);

        // Reset in the middle of a stream, then a clean restart.
        applyStimulus();
        waitBeats("midrst", 20);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        checkOutput("midrst_valid",    32'(bus.out_valid), 32'd0);
        checkOutput("midrst_rd_en",    32'(bus.ram_rd_en), 32'd0);
        checkOutput("midrst_busy",     32'(busy),          32'd0);
        checkOutput("midrst_checksum", 32'(checksum),      32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 checkOutput("midrst_idle_csum", 32'(checksum), 32'd0);
        applyStimulus();
        runCheck("restart", 24'd2080);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
